// File: rtl/fp_mul_norm_round_if.sv
// Valid/ready bundle between the mantissa multiplier and the normalize/round stage.
// master drives the product beat and out_ready; slave is the normalize/round pipeline.
interface fp_mul_norm_round_if #(
    parameter int MANT_W = 6,
    parameter int EXP_W  = 5
);
    logic                    in_valid;
    logic                    in_ready;
    logic [2*MANT_W-1:0]     prod;
    logic signed [EXP_W+1:0] exp_in;
    logic                    sign_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [MANT_W-2:0]       frac_out;
    logic [EXP_W-1:0]        exp_out;
    logic                    sign_out;
    logic                    ovf;
    logic                    unf;

    modport master (
        output in_valid, prod, exp_in, sign_in, out_ready,
        input  in_ready, out_valid, frac_out, exp_out, sign_out, ovf, unf
    );

    modport slave (
        input  in_valid, prod, exp_in, sign_in, out_ready,
        output in_ready, out_valid, frac_out, exp_out, sign_out, ovf, unf
    );
endinterface

// File: rtl/fp_mul_norm_round.sv
// Normalize, round-to-nearest-even and exponent classification of a raw mantissa product.
// Two-stage valid/ready pipeline: stage 1 normalizes, stage 2 rounds and holds the result.
module fp_mul_norm_round #(
    parameter int MANT_W = 6,
    parameter int EXP_W  = 5
) (
    input logic               clk,
    input logic               rst,
    fp_mul_norm_round_if.slave bus
);
    localparam int P  = 2 * MANT_W;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] E_ZERO = '0;

    // Stage 1 state: only the fraction is kept, the hidden bit is implicitly 1
    logic                 s1_valid_reg;
    logic [MANT_W-2:0]    s1_frac_reg;
    logic                 s1_guard_reg;
    logic                 s1_sticky_reg;
    logic                 s1_zero_reg;
    logic                 s1_sign_reg;
    logic signed [EW-1:0] s1_e_reg;

    logic                 s2_valid_reg;
    logic [MANT_W-2:0]    s2_frac_reg;
    logic [EXP_W-1:0]     s2_exp_reg;
    logic                 s2_sign_reg;
    logic                 s2_ovf_reg;
    logic                 s2_unf_reg;

    logic                 s2_en;
    logic                 in_ready;

    logic [MANT_W-2:0]    n_frac;
    logic                 n_guard;
    logic                 n_sticky;
    logic                 n_zero;
    logic signed [EW-1:0] n_e;

    logic                 round_up;
    logic                 carry;
    logic [MANT_W-2:0]    frac_sum;
    logic signed [EW-1:0] e_r;
    logic [MANT_W-2:0]    r_frac;
    logic [EXP_W-1:0]     r_exp;
    logic                 r_ovf;
    logic                 r_unf;

    assign s2_en    = !s2_valid_reg || bus.out_ready;
    assign in_ready = !s1_valid_reg || s2_en;

    always_comb begin
        n_zero = (bus.prod == '0);
        if (bus.prod[P-1]) begin
            n_frac   = bus.prod[P-2:MANT_W];
            n_guard  = bus.prod[MANT_W-1];
            n_sticky = |bus.prod[MANT_W-2:0];
            n_e      = bus.exp_in + EW'(1);
        end else begin
            n_frac   = bus.prod[P-3:MANT_W-1];
            n_guard  = bus.prod[MANT_W-2];
            n_sticky = |bus.prod[MANT_W-3:0];
            n_e      = bus.exp_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
        end else if (in_ready) begin
            s1_valid_reg <= bus.in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_ready && bus.in_valid) begin
            s1_frac_reg   <= n_frac;
            s1_guard_reg  <= n_guard;
            s1_sticky_reg <= n_sticky;
            s1_zero_reg   <= n_zero;
            s1_sign_reg   <= bus.sign_in;
            s1_e_reg      <= n_e;
        end
    end

    // An all-ones fraction that rounds up wraps to zero and bumps the exponent
    always_comb begin
        round_up = s1_guard_reg && (s1_sticky_reg || s1_frac_reg[0]);
        carry    = round_up && (&s1_frac_reg);
        frac_sum = s1_frac_reg + (MANT_W-1)'(round_up);
        e_r      = s1_e_reg + EW'(carry);
        r_frac   = frac_sum;
        r_exp    = e_r[EXP_W-1:0];
        r_ovf    = 1'b0;
        r_unf    = 1'b0;
        if (s1_zero_reg) begin
            r_frac = '0;
            r_exp  = '0;
        end else if (e_r >= E_MAX) begin
            r_ovf  = 1'b1;
            r_frac = '0;
            r_exp  = '1;
        end else if (e_r <= E_ZERO) begin
            r_unf  = 1'b1;
            r_frac = '0;
            r_exp  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_frac_reg  <= '0;
            s2_exp_reg   <= '0;
            s2_sign_reg  <= 1'b0;
            s2_ovf_reg   <= 1'b0;
            s2_unf_reg   <= 1'b0;
        end else if (s2_en) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_frac_reg <= r_frac;
                s2_exp_reg  <= r_exp;
                s2_sign_reg <= s1_sign_reg;
                s2_ovf_reg  <= r_ovf;
                s2_unf_reg  <= r_unf;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_reg;
    assign bus.frac_out  = s2_frac_reg;
    assign bus.exp_out   = s2_exp_reg;
    assign bus.sign_out  = s2_sign_reg;
    assign bus.ovf       = s2_ovf_reg;
    assign bus.unf       = s2_unf_reg;
endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Bench for fp_mul_norm_round: directed cases, backpressure, reset mid-stream and
// randomized streaming against an integer-arithmetic rounding model.
module tb_fp_mul_norm_round;
    localparam int MANT_W = 6;
    localparam int EXP_W  = 5;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    fp_mul_norm_round_if #(.MANT_W(MANT_W), .EXP_W(EXP_W)) bus ();

    fp_mul_norm_round #(.MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {sign, ovf, unf, exp[4:0], frac[4:0]}
    logic [12:0] obs;
    assign obs = {bus.sign_out, bus.ovf, bus.unf, bus.exp_out, bus.frac_out};

    // Reference: scale the product down by integer division and round to nearest even
    function automatic logic [12:0] model(input int p, input int e, input bit s);
        int sh, q, rem, half, ee;
        if (p == 0) return {s, 2'b00, 5'd0, 5'd0};
        if (p >= 2048) begin sh = 6; ee = e + 1; end
        else begin sh = 5; ee = e; end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 1 << (sh - 1);
        if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
        if (q == 64) begin q = 32; ee = ee + 1; end
        if (ee >= 31) return {s, 2'b10, 5'd31, 5'd0};
        if (ee <= 0) return {s, 2'b01, 5'd0, 5'd0};
        return {s, 2'b00, ee[4:0], q[4:0]};
    endfunction

    task automatic drive_beat(input int p, input int e, input bit s);
        bus.prod    = p[11:0];
        bus.exp_in  = e[6:0];
        bus.sign_in = s;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive_beat(0, 0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %0b want 0", bus.out_valid);
        end
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", obs);
        end
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %0b want 1", bus.in_ready);
        end
    endtask

    task automatic test_directed();
        int          dp[7] = '{'hBDE, 'h430, 'h410, 'hFE0, 'h800, 'h400, 0};
        int          de[7] = '{15, 10, 10, 10, 30, 0, 15};
        bit          ds[7] = '{0, 0, 0, 0, 0, 0, 1};
        logic [12:0] dx[7] = '{
            {1'b0, 2'b00, 5'd16, 5'b01111},
            {1'b0, 2'b00, 5'd10, 5'b00010},
            {1'b0, 2'b00, 5'd10, 5'b00000},
            {1'b0, 2'b00, 5'd12, 5'b00000},
            {1'b0, 2'b10, 5'd31, 5'b00000},
            {1'b0, 2'b01, 5'd0,  5'b00000},
            {1'b1, 2'b00, 5'd0,  5'b00000}};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b1;
            drive_beat(dp[i], de[i], ds[i]);
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_in_ready got %0b want 1", i, bus.in_ready);
            end
            @(negedge clk);
            bus.in_valid = 1'b0;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_early_valid got %0b want 0", i, bus.out_valid);
            end
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || obs !== dx[i]) begin
                errors++;
                $display("FAIL dir%0d_result valid %0b got %h want %h", i, bus.out_valid, obs, dx[i]);
            end
            $display("dir%0d prod=%h exp_in=%0d -> %h", i, dp[i], de[i], obs);
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] q[$];
        logic [12:0] held = '0;
        logic [12:0] want;
        bit          stalled = 0;
        bit          saw_block = 0;
        int          sent = 0, got = 0, p, e;
        bit          s;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            bus.out_ready = !(c >= 3 && c <= 6);
            bus.in_valid  = (sent < 4);
            p = $urandom_range(63, 32) * $urandom_range(63, 32);
            e = $urandom_range(30, 2);
            s = 1'($urandom_range(1, 0));
            drive_beat(p, e, s);
            #1;
            if (stalled) begin
                checks++;
                if (bus.out_valid !== 1'b1 || obs !== held) begin
                    errors++;
                    $display("FAIL bp_hold cyc %0d got %h want %h", c, obs, held);
                end
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = obs;
            if (bus.in_valid && !bus.in_ready) saw_block = 1;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                got++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra got %h want none", obs);
                end else begin
                    want = q.pop_front();
                    if (obs !== want) begin
                        errors++;
                        $display("FAIL bp_result got %h want %h", obs, want);
                    end
                    $display("bp out %0d %h", got, obs);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(p, e, s));
                sent++;
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (!saw_block) begin
            errors++;
            $display("FAIL bp_in_ready_drop got never want once");
        end
        checks++;
        if (got != 4 || sent != 4 || q.size() != 0) begin
            errors++;
            $display("FAIL bp_count got %0d sent %0d want 4", got, sent);
        end
    endtask

    task automatic test_reset_mid();
        logic [12:0] want;
        want = {1'b0, 2'b00, 5'd16, 5'b01111};
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        drive_beat('h430, 10, 1'b1);
        @(negedge clk);
        drive_beat('h410, 10, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || obs !== 13'd0) begin
            errors++;
            $display("FAIL rstmid_flush valid %0b got %h want 0", bus.out_valid, obs);
        end
        bus.in_valid = 1'b1;
        drive_beat('hBDE, 15, 1'b0);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_in_ready got %0b want 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_stale got %0b want 0", bus.out_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || obs !== want) begin
            errors++;
            $display("FAIL rstmid_result valid %0b got %h want %h", bus.out_valid, obs, want);
        end
        $display("rstmid result %h", obs);
    endtask

    task automatic test_random();
        logic [12:0] q[$];
        logic [12:0] want;
        int          p, e, n = 0;
        bit          s;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            bus.in_valid  = ($urandom_range(3, 0) != 0) && (c < 380);
            bus.out_ready = (c >= 380) || ($urandom_range(2, 0) != 0);
            p = ($urandom_range(15, 0) == 0) ? 0 : $urandom_range(63, 32) * $urandom_range(63, 32);
            e = $urandom_range(44, 0) - 4;
            s = 1'($urandom_range(1, 0));
            drive_beat(p, e, s);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                n++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra got %h want none", obs);
                end else begin
                    want = q.pop_front();
                    if (obs !== want) begin
                        errors++;
                        $display("FAIL rand_result %0d got %h want %h", n, obs, want);
                    end
                    $display("rand out %0d %h", n, obs);
                end
            end
            if (bus.in_valid && bus.in_ready) q.push_back(model(p, e, s));
        end
        bus.in_valid = 1'b0;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rand_drain got %0d left want 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
